// File: rtl/gray_pkg.sv
// Shared constants and Gray/binary helpers for the Gray counter family.
// Helpers work on GRAY_MAX_WIDTH-bit vectors; 'width' selects the live low bits.
package gray_pkg;

    localparam int GRAY_WIDTH_DEFAULT = 5;
    localparam int GRAY_MAX_WIDTH     = 16;
    localparam logic DIR_UP           = 1'b1;
    localparam logic DIR_DOWN         = 1'b0;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] bin,
        input int                        width
    );
        logic [GRAY_MAX_WIDTH-1:0] mask;
        mask = {GRAY_MAX_WIDTH{1'b1}} >> (GRAY_MAX_WIDTH - width);
        return (bin ^ (bin >> 1)) & mask;
    endfunction

    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
        input logic [GRAY_MAX_WIDTH-1:0] gray,
        input int                        width
    );
        logic [GRAY_MAX_WIDTH-1:0] bin;
        logic                      acc;
        acc = 1'b0;
        bin = {GRAY_MAX_WIDTH{1'b0}};
        for (int i = GRAY_MAX_WIDTH - 1; i >= 0; i--) begin
            if (i < width) begin
                acc    = acc ^ gray[i];
                bin[i] = acc;
            end else begin
                bin[i] = 1'b0;
            end
        end
        return bin;
    endfunction

    // True when exactly one bit of the difference vector is set.
    function automatic logic is_one_hot(input logic [GRAY_MAX_WIDTH-1:0] diff);
        return (diff != {GRAY_MAX_WIDTH{1'b0}}) &&
               ((diff & (diff - {{(GRAY_MAX_WIDTH-1){1'b0}}, 1'b1})) == {GRAY_MAX_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/gray_counter_param_conv.sv
// Combinational Gray-to-binary converter (prefix XOR from the MSB) for load values.
module gray2bin_conv #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic acc_s;

    // Running XOR from the MSB down gives each binary bit.
    always_comb begin
        acc_s = 1'b0;
        bin   = {WIDTH{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc_s  = acc_s ^ gray[i];
            bin[i] = acc_s;
        end
    end

endmodule

// File: rtl/gray_counter_param.sv
// Up/down Gray counter with load, wrap or saturate, registered binary and Gray outputs.
// Optional macro GRAY_CHECK_EN adds a sticky gray_error output.
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int WIDTH    = GRAY_WIDTH_DEFAULT,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] salida_gray,
    output logic [WIDTH-1:0] salida_bin,
    output logic             wrap
`ifdef GRAY_CHECK_EN
    ,
    output logic             gray_error
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrap_r;
    logic [WIDTH-1:0] load_bin_s;
    logic [WIDTH-1:0] next_bin_s;
    logic [WIDTH-1:0] next_gray_s;
    logic             next_wrap_s;
    logic             step_s;

    gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
        .gray (load_gray),
        .bin  (load_bin_s)
    );

    // Next count and wrap flag; load beats enable, saturation holds at the ends.
    always_comb begin
        next_bin_s  = bin_r;
        next_wrap_s = 1'b0;
        step_s      = 1'b0;
        if (load) begin
            next_bin_s = load_bin_s;
        end else if (enable) begin
            step_s = 1'b1;
            if (up_down == DIR_UP) begin
                if (bin_r == MAX_VAL) begin
                    next_wrap_s = 1'b1;
                    if (SATURATE) begin
                        next_bin_s = bin_r;
                    end else begin
                        next_bin_s = ZERO_VAL;
                    end
                end else begin
                    next_bin_s  = bin_r + ONE_VAL;
                    next_wrap_s = SATURATE && (next_bin_s == MAX_VAL);
                end
            end else begin
                if (bin_r == ZERO_VAL) begin
                    next_wrap_s = 1'b1;
                    if (SATURATE) begin
                        next_bin_s = bin_r;
                    end else begin
                        next_bin_s = MAX_VAL;
                    end
                end else begin
                    next_bin_s  = bin_r - ONE_VAL;
                    next_wrap_s = SATURATE && (next_bin_s == ZERO_VAL);
                end
            end
        end else begin
            next_bin_s = bin_r;
        end
        next_gray_s = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(next_bin_s), WIDTH));
    end

    // Count, Gray image and wrap pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_r  <= ZERO_VAL;
            gray_r <= ZERO_VAL;
            wrap_r <= 1'b0;
        end else begin
            bin_r  <= next_bin_s;
            gray_r <= next_gray_s;
            wrap_r <= next_wrap_s;
        end
    end

    assign salida_bin  = bin_r;
    assign salida_gray = gray_r;
    assign wrap        = wrap_r;

`ifdef GRAY_CHECK_EN
    logic gray_error_r;

    // Sticky flag: a real count step (not a saturated hold) must flip exactly one Gray bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_error_r <= 1'b0;
        end else if (step_s && (next_gray_s != gray_r) &&
                     !is_one_hot(GRAY_MAX_WIDTH'(next_gray_s ^ gray_r))) begin
            gray_error_r <= 1'b1;
        end else begin
            gray_error_r <= gray_error_r;
        end
    end

    assign gray_error = gray_error_r;
`endif

endmodule

// File: doc/gray_counter_param.md
GRAY_COUNTER_PARAM -- requirements
Module: gray_counter_param

Interface
REQ-001 Parameter WIDTH SHALL default to 5 and set the counter and output width in bits (legal range 2..16).
REQ-002 Parameter SATURATE SHALL default to 0; 0 selects modulo wrap, 1 selects hold at the end value.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  count-step request for this cycle.
REQ-007 up_down  input  1  count direction: 1 is up, 0 is down.
REQ-008 load  input  1  synchronous load request.
REQ-009 load_gray  input  WIDTH  load value, Gray-coded.
REQ-010 salida_gray  output  WIDTH  registered Gray-coded count.
REQ-011 salida_bin  output  WIDTH  registered binary count.
REQ-012 wrap  output  1  registered one-cycle pulse on wrap-around or on reaching saturation.

Function
REQ-013 All state SHALL update only on the rising edge of clk, except for reset.
- Inputs sampled at edge k are reflected on the outputs immediately after edge k (latency of one edge).
REQ-014 Priority SHALL be reset > load > enable > hold.
REQ-015 When load=1, the counter SHALL take the value load_gray converted to binary.
- salida_gray then equals load_gray.
- wrap=0 in that cycle.
- enable and up_down are ignored.
REQ-016 When enable=1 and load=0, the binary count SHALL step by +1 if up_down=1 and by -1 if up_down=0.
- Arithmetic is modulo 2^WIDTH.
REQ-017 salida_gray SHALL always equal salida_bin XOR (salida_bin >> 1), registered in the same cycle as salida_bin.
REQ-018 With SATURATE=0:
- An up-step from 2^WIDTH-1 SHALL yield 0 and pulse wrap.
- A down-step from 0 SHALL yield 2^WIDTH-1 and pulse wrap.
REQ-019 With SATURATE=1:
- An up-step at 2^WIDTH-1 or a down-step at 0 SHALL hold the value and assert wrap=1 for every such blocked step.
- A step that arrives at an end value SHALL pulse wrap.
REQ-020 wrap SHALL be 0 in every cycle not covered by REQ-018/REQ-019.
REQ-021 With enable=0 and load=0, all outputs SHALL hold, and wrap SHALL return to 0.
REQ-022 A direction change between consecutive enabled cycles SHALL take effect on the very next step, with no idle cycle.
REQ-023 Consecutive count steps (no load) SHALL change salida_gray in exactly one bit, wrap step included.

Reset
REQ-024 While reset=1, salida_bin, salida_gray, wrap and all internal state SHALL be 0, independent of clk.
REQ-025 Reset asserted mid-count SHALL clear state immediately.
- The first step after deassertion starts from 0.
- enable or load sampled on the first edge after deassertion SHALL be honoured.

Configuration
REQ-026 Macro GRAY_CHECK_EN SHALL, when defined, add output gray_error (1 bit, registered, sticky).
REQ-027 With GRAY_CHECK_EN defined, gray_error SHALL set when two consecutive count-step values of salida_gray differ in other than one bit.
- Load cycles and held cycles are excluded.
- gray_error clears only on reset.
REQ-028 Without GRAY_CHECK_EN, the gray_error port and its logic SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-029 A shared package gray_pkg SHALL hold:
- the constants GRAY_WIDTH_DEFAULT=5, DIR_UP=1 and DIR_DOWN=0;
- functions bin2gray and gray2bin, parameterised by width.
REQ-030 One sub-module, gray2bin_conv (combinational, parameter WIDTH), SHALL perform the load_gray conversion.
- Conversion is a prefix XOR from the MSB.

Verification (WIDTH=5 unless stated)
REQ-031 Reset then enable=1, up_down=1 for 33 cycles:
- salida_gray follows 00000,00001,00011,00010,... through 10000 then 00000.
- wrap pulses exactly once, on the 31->0 step.
- Every step is a one-bit change.
REQ-032 load=1, load_gray=11000 (binary 10000), then one down-step:
- after the load: salida_bin=16, salida_gray=11000;
- after the step: salida_bin=15, salida_gray=01000.
REQ-033 SATURATE=1, load binary 31 (gray 10000), enable=1, up_down=1 for 3 cycles:
- salida_bin stays 31;
- wrap=1 in each cycle.
- Then up_down=0 gives salida_bin=30 and wrap=0.
REQ-034 reset pulsed asynchronously mid-cycle at count 12:
- outputs go to 0 before the next clk edge;
- the first enabled up-step after release gives salida_bin=1.
REQ-035 load=1 and enable=1 in the same cycle with load_gray=00110:
- salida_bin=4, with no extra step;
- wrap=0.
REQ-036 With GRAY_CHECK_EN, a full up and down sweep at WIDTH=8 SHALL leave gray_error=0.
- Without the macro, the bench SHALL compile with no gray_error port.
